frame_compositor: RTL and testbench

FRAME_COMPOSITOR -- requirements
Module: frame_compositor

---
 rtl/frame_compositor_pkg.sv | 27 ++
 rtl/frame_compositor_scale.sv | 23 ++
 rtl/frame_compositor.sv | 148 ++++++++++++++
 tb/tb_frame_compositor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_compositor_pkg.sv
// ==========================================================================
// frame_compositor_pkg : shared constants and FSM encoding | rev 1.0
// ==========================================================================
`default_nettype none

package frame_compositor_pkg;

  localparam int C_WIDTH  = 96;
  localparam int C_HEIGHT = 64;
  localparam int C_PIXELS = C_WIDTH * C_HEIGHT;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  localparam logic [3:0] FADE_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_SHOW     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWAP     = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/frame_compositor_scale.sv
// ==========================================================================
// rgb565_scale : per-channel RGB565 brightness scaling by level/8 | rev 1.0
// ==========================================================================
`default_nettype none

module rgb565_scale
  import frame_compositor_pkg::*;
(
  input  logic [15:0] color_i,
  input  logic [3:0]  level_i,
  output logic [15:0] color_o
);

  // Products never exceed channel_max*8, so the >>3 result always fits the channel.
  always_comb begin
    color_o[15:11] = R_W'(({3'b000, color_i[15:11]} * {4'b0000, level_i}) >> 3);
    color_o[10:5]  = G_W'(({3'b000, color_i[10:5]}  * {5'b00000, level_i}) >> 3);
    color_o[4:0]   = B_W'(({3'b000, color_i[4:0]}   * {4'b0000, level_i}) >> 3);
  end

endmodule

`default_nettype wire

// File: rtl/frame_compositor.sv
// ==========================================================================
// frame_compositor : sprite-over-background compositor with level fades | rev 1.0
// ==========================================================================
`default_nettype none

module frame_compositor
  import frame_compositor_pkg::*;
#(
  parameter int WIDTH           = C_WIDTH,
  parameter int HEIGHT          = C_HEIGHT,
  parameter int SPR_SIZE        = 8,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] pixel_index_i,
  input  logic        frame_begin_i,
  output logic [12:0] rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic [1:0]  rom_sel_o,
  input  logic        level_req_i,
  input  logic [1:0]  level_next_i,
  input  logic [6:0]  player_x_i,
  input  logic [5:0]  player_y_i,
  input  logic [15:0] player_color_i,
  output logic [15:0] pixel_color_o,
  output logic        busy_o
);

  localparam int PIXELS = WIDTH * HEIGHT;

  logic [12:0] idx_q;
  logic        hit_q;
  logic        oob_q;
  logic [15:0] pixel_color_q;

  state_e      state_q;
  logic [3:0]  fade_lvl_q;
  logic [1:0]  rom_sel_q;
  logic [1:0]  pending_q;
  logic [7:0]  frame_cnt_q;
  logic        busy_q;

  logic [7:0]  col;
  logic [7:0]  row;
  logic [7:0]  spr_x;
  logic [7:0]  spr_y;
  logic        hit;
  logic        oob;
  logic        step_due;
  logic [15:0] base_color;
  logic [15:0] faded_color;

  // 8-bit compares keep player_x+SPR_SIZE from wrapping past the right/bottom edge.
  always_comb begin
    col        = 8'(idx_q % 13'(WIDTH));
    row        = 8'(idx_q / 13'(WIDTH));
    spr_x      = {1'b0, player_x_i};
    spr_y      = {2'b00, player_y_i};
    hit        = (col >= spr_x) && (col < spr_x + 8'(SPR_SIZE)) &&
                 (row >= spr_y) && (row < spr_y + 8'(SPR_SIZE));
    oob        = (idx_q >= 13'(PIXELS));
    step_due   = frame_begin_i && (frame_cnt_q == 8'(FRAMES_PER_STEP - 1));
    base_color = oob_q ? 16'h0000 : (hit_q ? player_color_i : rom_data_i);
  end

  rgb565_scale u_scale (
    .color_i (base_color),
    .level_i (fade_lvl_q),
    .color_o (faded_color)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      hit_q         <= 1'b0;
      oob_q         <= 1'b0;
      pixel_color_q <= '0;
    end else begin
      idx_q         <= pixel_index_i;
      hit_q         <= hit;
      oob_q         <= oob;
      pixel_color_q <= faded_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SHOW;
      fade_lvl_q  <= FADE_FULL;
      rom_sel_q   <= '0;
      pending_q   <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_SHOW: begin
          if (level_req_i && (level_next_i != rom_sel_q)) begin
            pending_q   <= level_next_i;
            frame_cnt_q <= '0;
            state_q     <= ST_FADE_OUT;
            busy_q      <= 1'b1;
          end
        end
        ST_FADE_OUT: begin
          if (level_req_i) pending_q <= level_next_i;
          if (frame_begin_i) frame_cnt_q <= step_due ? 8'd0 : frame_cnt_q + 8'd1;
          if (step_due) begin
            fade_lvl_q <= fade_lvl_q - 4'd1;
            if (fade_lvl_q == 4'd1) begin
              rom_sel_q <= pending_q;
              state_q   <= ST_SWAP;
            end
          end
        end
        ST_SWAP: begin
          if (frame_begin_i) begin
            frame_cnt_q <= '0;
            state_q     <= ST_FADE_IN;
          end
        end
        ST_FADE_IN: begin
          if (frame_begin_i) frame_cnt_q <= step_due ? 8'd0 : frame_cnt_q + 8'd1;
          if (step_due) begin
            fade_lvl_q <= fade_lvl_q + 4'd1;
            if (fade_lvl_q == FADE_FULL - 4'd1) begin
              state_q <= ST_SHOW;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_SHOW;
          fade_lvl_q <= FADE_FULL;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o    = idx_q;
  assign rom_sel_o     = rom_sel_q;
  assign pixel_color_o = pixel_color_q;
  assign busy_o        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_compositor.sv
// ==========================================================================
// tb_frame_compositor : directed self-checking bench for frame_compositor | rev 1.0
// ==========================================================================
`default_nettype none

module tb_frame_compositor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] pixel_index_i = '0;
  logic        frame_begin_i = 1'b0;
  logic [12:0] rom_addr_o;
  logic [15:0] rom_data_i = '0;
  logic [1:0]  rom_sel_o;
  logic        level_req_i = 1'b0;
  logic [1:0]  level_next_i = '0;
  logic [6:0]  player_x_i = 7'd95;
  logic [5:0]  player_y_i = 6'd63;
  logic [15:0] player_color_i = 16'hABCD;
  logic [15:0] pixel_color_o;
  logic        busy_o;

  logic        rom_ovr = 1'b0;
  logic [15:0] rom_val = '0;

  int n_tests = 0;
  int n_fail  = 0;

  frame_compositor dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_index_i  (pixel_index_i),
    .frame_begin_i  (frame_begin_i),
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .rom_sel_o      (rom_sel_o),
    .level_req_i    (level_req_i),
    .level_next_i   (level_next_i),
    .player_x_i     (player_x_i),
    .player_y_i     (player_y_i),
    .player_color_i (player_color_i),
    .pixel_color_o  (pixel_color_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [1:0] s, input logic [12:0] a);
    return {s, 1'b0, a} ^ 16'h5A3C;
  endfunction

  // Synchronous ROM model: data follows the address by one clock.
  always @(posedge clk) rom_data_i <= rom_ovr ? rom_val : rom_fn(rom_sel_o, rom_addr_o);

  function automatic logic [15:0] scale(input logic [15:0] c, input int l);
    int r, g, b;
    r = (int'(c[15:11]) * l) / 8;
    g = (int'(c[10:5]) * l) / 8;
    b = (int'(c[4:0]) * l) / 8;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  function automatic logic [15:0] exp_pix(input int idx, input int x, input int y,
                                          input logic [15:0] pc);
    int col, row;
    if (idx >= 6144) return 16'h0000;
    col = idx % 96;
    row = idx / 96;
    if (col >= x && col < x + 8 && row >= y && row < y + 8) return pc;
    return rom_fn(2'd0, 13'(idx));
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_settle();
    frame_begin_i = 1'b1;
    tick();
    frame_begin_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic req(input logic [1:0] lvl);
    level_req_i  = 1'b1;
    level_next_i = lvl;
    tick();
    level_req_i  = 1'b0;
  endtask

  typedef struct {
    logic [12:0] idx;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] pc;
    logic [15:0] rom;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lvl;
    vecs[0]  = '{13'd1930, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'hF800};
    vecs[1]  = '{13'd1929, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'h1234};
    vecs[2]  = '{13'd2697, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'h1234};
    vecs[3]  = '{13'd1937, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'hF800};
    vecs[4]  = '{13'd1938, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'h1234};
    vecs[5]  = '{13'd2609, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'hF800};
    vecs[6]  = '{13'd1834, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'h1234};
    vecs[7]  = '{13'd2698, 7'd10, 6'd20, 16'hF800, 16'h1234, 16'h1234};
    vecs[8]  = '{13'd6144, 7'd0,  6'd60, 16'hF800, 16'h1234, 16'h0000};
    vecs[9]  = '{13'd8191, 7'd31, 6'd60, 16'hF800, 16'h1234, 16'h0000};
    vecs[10] = '{13'd6143, 7'd95, 6'd63, 16'h07E0, 16'h1234, 16'h07E0};
    vecs[11] = '{13'd6142, 7'd95, 6'd63, 16'h07E0, 16'h1234, 16'h1234};
    vecs[12] = '{13'd0,    7'd95, 6'd63, 16'h07E0, 16'hBEEF, 16'hBEEF};

    repeat (3) tick();
    check("reset_pixel_color", pixel_color_o, 16'h0000);
    check("reset_rom_addr", {3'b000, rom_addr_o}, 16'h0000);
    check("reset_busy", {15'd0, busy_o}, 16'h0000);
    check("reset_rom_sel", {14'd0, rom_sel_o}, 16'h0000);
    rst = 1'b0;
    tick();

    // Table vectors: hold each pixel long enough to flush the pipeline.
    rom_ovr = 1'b1;
    for (int v = 0; v < 13; v++) begin
      pixel_index_i  = vecs[v].idx;
      player_x_i     = vecs[v].x;
      player_y_i     = vecs[v].y;
      player_color_i = vecs[v].pc;
      rom_val        = vecs[v].rom;
      repeat (4) tick();
      check($sformatf("vec%0d", v), pixel_color_o, vecs[v].exp);
    end

    // Full sweep at full brightness; 3-cycle latency against the ROM model.
    rom_ovr        = 1'b0;
    player_x_i     = 7'd95;
    player_y_i     = 6'd63;
    player_color_i = 16'hABCD;
    for (int k = 0; k < 6150; k++) begin
      pixel_index_i = (k < 6148) ? 13'(k) : 13'd0;
      tick();
      if (k == 1) check("sweep_rom_addr", {3'b000, rom_addr_o}, 16'd1);
      if (k >= 2) check($sformatf("sweep_idx%0d", k - 2), pixel_color_o,
                        exp_pix(k - 2, 95, 63, 16'hABCD));
    end

    // Fade out to level 2 and back, observing brightness on a white pixel.
    rom_ovr       = 1'b1;
    rom_val       = 16'hFFFF;
    pixel_index_i = 13'd0;
    repeat (4) tick();
    check("show_full_white", pixel_color_o, 16'hFFFF);
    req(2'd2);
    check("busy_after_req", {15'd0, busy_o}, 16'h0001);
    for (int f = 1; f <= 33; f++) begin
      if (f == 20) req(2'd1);
      frame_settle();
      lvl = (f <= 16) ? 8 - f / 2 : (f - 17) / 2;
      check($sformatf("fade_f%0d", f), pixel_color_o, scale(16'hFFFF, lvl));
      check($sformatf("busy_f%0d", f), {15'd0, busy_o}, (f < 33) ? 16'd1 : 16'd0);
      check($sformatf("sel_f%0d", f), {14'd0, rom_sel_o}, (f >= 16) ? 16'd2 : 16'd0);
      if (f == 8) check("fade4_white", pixel_color_o, 16'h7BEF);
    end

    req(2'd2);
    tick();
    check("same_level_ignored", {15'd0, busy_o}, 16'h0000);

    // Retarget during fade-out: last request wins.
    req(2'd1);
    frame_settle();
    frame_settle();
    req(2'd3);
    for (int f = 3; f <= 16; f++) frame_settle();
    check("retarget_sel_swap", {14'd0, rom_sel_o}, 16'd3);
    check("retarget_busy_swap", {15'd0, busy_o}, 16'd1);
    for (int f = 17; f <= 33; f++) frame_settle();
    check("retarget_sel_done", {14'd0, rom_sel_o}, 16'd3);
    check("retarget_busy_done", {15'd0, busy_o}, 16'd0);

    // Reset in the middle of fade-in abandons the transition.
    req(2'd1);
    for (int f = 1; f <= 19; f++) frame_settle();
    check("pre_rst_sel", {14'd0, rom_sel_o}, 16'd1);
    check("pre_rst_dim", pixel_color_o, scale(16'hFFFF, 1));
    rst = 1'b1;
    tick();
    check("rst_sel", {14'd0, rom_sel_o}, 16'd0);
    check("rst_busy", {15'd0, busy_o}, 16'd0);
    check("rst_pixel", pixel_color_o, 16'h0000);
    rst = 1'b0;
    repeat (4) tick();
    check("rst_full_bright", pixel_color_o, 16'hFFFF);
    frame_settle();
    check("rst_still_show", {15'd0, busy_o}, 16'd0);
    check("rst_still_bright", pixel_color_o, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
